// File: rtl/tb_exit_status_periph_if.sv
// Data-bus bundle between the core's LSU (master) and the TB exit/status peripheral (slave).
// Signal names keep the peripheral-side _i/_o suffixes so both ends read the same way.
interface tb_exit_status_periph_if;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/tb_exit_status_periph.sv
// Testbench peripheral: pass/fail/exit signalling, stdout characters, scratch register
// and a 64-bit cycle counter with a tear-free high-word shadow.
module tb_exit_status_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter logic [31:0] PASS_MAGIC = 32'd123456789,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    tb_exit_status_periph_if.slave        bus,
    output logic                          tests_passed_o,
    output logic                          tests_failed_o,
    output logic                          exit_valid_o,
    output logic [31:0]                   exit_value_o,
    output logic                          print_valid_o,
    output logic [7:0]                    print_char_o
);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                r[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    logic        hit_s, acc_s, wr_s, rd_s, full_be_s, unused_s;
    logic [2:0]  off_s;

    logic [63:0] cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d, scratch_q, scratch_d, exit_value_q, exit_value_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  print_char_q, print_char_d;
    logic        term_q, term_d, rvalid_q, rvalid_d;
    logic        passed_q, passed_d, failed_q, failed_d;
    logic        exit_valid_q, exit_valid_d, print_valid_q, print_valid_d;

    assign hit_s     = (bus.addr_i[31:5] == BASE_ADDR[31:5]);
    assign acc_s     = bus.req_i & hit_s;
    assign wr_s      = acc_s & bus.we_i;
    assign rd_s      = acc_s & ~bus.we_i;
    assign full_be_s = (bus.be_i == 4'hF);
    assign off_s     = bus.addr_i[4:2];
    assign unused_s  = ^bus.addr_i[1:0];

    // Register decode: next-state for all storage, pulses and the read response.
    always_comb begin
        cnt_d         = cnt_q + 64'd1;
        shadow_d      = shadow_q;
        scratch_d     = scratch_q;
        exit_value_d  = exit_value_q;
        print_char_d  = print_char_q;
        term_d        = term_q;
        rvalid_d      = acc_s;
        rdata_d       = 32'd0;
        passed_d      = 1'b0;
        failed_d      = 1'b0;
        exit_valid_d  = 1'b0;
        print_valid_d = 1'b0;
        case (off_s)
            3'd0: begin
                if (wr_s && bus.be_i[0]) begin
                    print_char_d  = bus.wdata_i[7:0];
                    print_valid_d = 1'b1;
                end else begin
                    print_valid_d = 1'b0;
                end
            end
            3'd1: begin
                if (wr_s && full_be_s && !term_q) begin
                    term_d   = 1'b1;
                    passed_d = (bus.wdata_i == PASS_MAGIC);
                    failed_d = (bus.wdata_i != PASS_MAGIC);
                end else begin
                    term_d = term_q;
                end
            end
            3'd2: begin
                if (wr_s && full_be_s && !term_q) begin
                    term_d       = 1'b1;
                    exit_value_d = bus.wdata_i;
                    exit_valid_d = 1'b1;
                end else if (rd_s) begin
                    rdata_d = exit_value_q;
                end else begin
                    rdata_d = 32'd0;
                end
            end
            3'd3: begin
                // High word is captured with the low word so a later HI read cannot tear.
                if (rd_s) begin
                    rdata_d  = cnt_q[31:0];
                    shadow_d = cnt_q[63:32];
                end else begin
                    shadow_d = shadow_q;
                end
            end
            3'd4: begin
                if (rd_s) begin
                    rdata_d = shadow_q;
                end else begin
                    rdata_d = 32'd0;
                end
            end
            3'd5: begin
                if (wr_s) begin
                    scratch_d = merge_bytes(scratch_q, bus.wdata_i, bus.be_i);
                end else if (rd_s) begin
                    rdata_d = scratch_q;
                end else begin
                    scratch_d = scratch_q;
                end
            end
            default: begin
                if (rd_s) begin
                    rdata_d = ERR_RDATA;
                end else begin
                    rdata_d = 32'd0;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q         <= 64'd0;
            shadow_q      <= 32'd0;
            scratch_q     <= 32'd0;
            exit_value_q  <= 32'd0;
            print_char_q  <= 8'd0;
            term_q        <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= 32'd0;
            passed_q      <= 1'b0;
            failed_q      <= 1'b0;
            exit_valid_q  <= 1'b0;
            print_valid_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            scratch_q     <= scratch_d;
            exit_value_q  <= exit_value_d;
            print_char_q  <= print_char_d;
            term_q        <= term_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            passed_q      <= passed_d;
            failed_q      <= failed_d;
            exit_valid_q  <= exit_valid_d;
            print_valid_q <= print_valid_d;
        end
    end

    assign bus.gnt_o      = acc_s;
    assign bus.rvalid_o   = rvalid_q;
    assign bus.rdata_o    = rdata_q;
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;
    assign print_valid_o  = print_valid_q;
    assign print_char_o   = print_char_q;

endmodule

// File: tb/tb_tb_exit_status_periph.sv
// Self-checking bench for tb_exit_status_periph: directed scenarios plus randomized
// traffic checked against a register-level reference model.
module tb_tb_exit_status_periph;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam logic [31:0] MAGIC = 32'd123456789;
    localparam logic [31:0] ERR   = 32'hDEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tests_passed_o, tests_failed_o, exit_valid_o, print_valid_o;
    logic [31:0] exit_value_o;
    logic [7:0]  print_char_o;

    tb_exit_status_periph_if bus();

    tb_exit_status_periph #(.BASE_ADDR(BASE), .PASS_MAGIC(MAGIC), .ERR_RDATA(ERR)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus),
        .tests_passed_o(tests_passed_o), .tests_failed_o(tests_failed_o),
        .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o),
        .print_valid_o(print_valid_o), .print_char_o(print_char_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference cycle count: clock edges seen since reset release, plus an offset
    // adjusted whenever the bench preloads the counter.
    logic [63:0] m_ticks;
    logic [63:0] m_off = 64'd0;
    logic [63:0] c_at_drive;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) m_ticks <= 64'd0;
        else         m_ticks <= m_ticks + 64'd1;
    end

    // Observed response: {rvalid, passed, failed, exit_valid, print_valid}
    logic        o_gnt;
    logic [4:0]  o_st;
    logic [31:0] o_rdata, o_exit;
    logic [7:0]  o_pchar;

    // One bus cycle starting at a falling edge; samples the response one cycle later.
    task automatic cycle(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_i = req; bus.we_i = we; bus.be_i = be; bus.addr_i = addr; bus.wdata_i = wdata;
        c_at_drive = m_ticks + m_off;
        #1 o_gnt = bus.gnt_o;
        @(negedge clk_i);
        o_st    = {bus.rvalid_o, tests_passed_o, tests_failed_o, exit_valid_o, print_valid_o};
        o_rdata = bus.rdata_o;
        o_exit  = exit_value_o;
        o_pchar = print_char_o;
        bus.req_i = 1'b0;
    endtask

    task automatic do_reset();
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0; bus.addr_i = 32'd0; bus.wdata_i = 32'd0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        m_off  = 64'd0;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0; bus.addr_i = BASE; bus.wdata_i = 32'd0;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({bus.rvalid_o, tests_passed_o, tests_failed_o, exit_valid_o, print_valid_o, bus.gnt_o} !== 6'b0 ||
            bus.rdata_o !== 32'd0 || exit_value_o !== 32'd0 || print_char_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%0b rdata=%h exit=%h char=%h, expected all zero",
                     bus.rvalid_o, bus.rdata_o, exit_value_o, print_char_o);
        end
        m_off  = 64'd0;
        rst_ni = 1'b1;
    endtask

    task automatic test_print();
        cycle(1'b1, 1'b1, 4'h1, BASE + 32'h00, 32'h0000_0041);
        checks++;
        if (o_st !== 5'b10001 || o_pchar !== 8'h41) begin
            errors++; $display("FAIL print_pulse: got st=%b char=%h, expected st=10001 char=41", o_st, o_pchar);
        end
        cycle(1'b0, 1'b0, 4'h0, BASE, 32'd0);
        checks++;
        if (o_st !== 5'b00000 || o_pchar !== 8'h41) begin
            errors++; $display("FAIL print_one_cycle: got st=%b char=%h, expected st=00000 char=41", o_st, o_pchar);
        end
        cycle(1'b1, 1'b1, 4'hE, BASE + 32'h00, 32'h0000_0042);
        checks++;
        if (o_st !== 5'b10000 || o_pchar !== 8'h41) begin
            errors++; $display("FAIL print_no_be0: got st=%b char=%h, expected st=10000 char=41", o_st, o_pchar);
        end
    endtask

    task automatic test_pass_fail();
        cycle(1'b1, 1'b1, 4'hF, BASE + 32'h04, MAGIC);
        checks++;
        if (o_st !== 5'b11000) begin
            errors++; $display("FAIL pass_pulse: got st=%b, expected st=11000", o_st);
        end
        cycle(1'b0, 1'b0, 4'h0, BASE, 32'd0);
        checks++;
        if (o_st !== 5'b00000) begin
            errors++; $display("FAIL pass_one_cycle: got st=%b, expected st=00000", o_st);
        end
        cycle(1'b1, 1'b1, 4'hF, BASE + 32'h04, 32'd1);
        checks++;
        if (o_st !== 5'b10000) begin
            errors++; $display("FAIL fail_after_term: got st=%b, expected st=10000", o_st);
        end
    endtask

    task automatic test_exit();
        do_reset();
        cycle(1'b1, 1'b1, 4'h7, BASE + 32'h04, 32'd1);
        checks++;
        if (o_st !== 5'b10000) begin
            errors++; $display("FAIL passfail_partial_be: got st=%b, expected st=10000", o_st);
        end
        cycle(1'b1, 1'b1, 4'hF, BASE + 32'h08, 32'd5);
        checks++;
        if (o_st !== 5'b10010 || o_exit !== 32'd5) begin
            errors++; $display("FAIL exit_pulse: got st=%b value=%h, expected st=10010 value=5", o_st, o_exit);
        end
        cycle(1'b1, 1'b1, 4'hF, BASE + 32'h08, 32'd9);
        checks++;
        if (o_st !== 5'b10000 || o_exit !== 32'd5) begin
            errors++; $display("FAIL exit_second: got st=%b value=%h, expected st=10000 value=5", o_st, o_exit);
        end
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h08, 32'd0);
        checks++;
        if (o_st !== 5'b10000 || o_rdata !== 32'd5) begin
            errors++; $display("FAIL exit_read: got st=%b rdata=%h, expected st=10000 rdata=5", o_st, o_rdata);
        end
    endtask

    // Preload the counter, then LO/HI/LO/HI back to back across a carry.
    task test_counter(input logic [63:0] start, input logic [31:0] hi1, input logic [31:0] hi2);
        force dut.cnt_q = start;
        m_off = start - m_ticks;
        #1 release dut.cnt_q;
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h0C, 32'd0);
        checks++;
        if (o_st !== 5'b10000 || o_rdata !== start[31:0]) begin
            errors++; $display("FAIL cnt_lo1: got st=%b rdata=%h, expected st=10000 rdata=%h", o_st, o_rdata, start[31:0]);
        end
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'd0);
        checks++;
        if (o_st !== 5'b10000 || o_rdata !== hi1) begin
            errors++; $display("FAIL cnt_hi1: got rdata=%h, expected %h", o_rdata, hi1);
        end
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h0C, 32'd0);
        checks++;
        if (o_rdata !== 32'd1 || c_at_drive[31:0] !== 32'd1) begin
            errors++; $display("FAIL cnt_lo2: got rdata=%h, expected 00000001", o_rdata);
        end
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'd0);
        checks++;
        if (o_rdata !== hi2) begin
            errors++; $display("FAIL cnt_hi2: got rdata=%h, expected %h", o_rdata, hi2);
        end
    endtask

    task automatic test_scratch_map();
        cycle(1'b1, 1'b1, 4'hF, BASE + 32'h14, 32'hAABB_CCDD);
        cycle(1'b1, 1'b1, 4'h2, BASE + 32'h14, 32'h0000_1100);
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h14, 32'd0);
        checks++;
        if (o_st !== 5'b10000 || o_rdata !== 32'hAABB_11DD) begin
            errors++; $display("FAIL scratch_merge: got rdata=%h, expected aabb11dd", o_rdata);
        end
        cycle(1'b1, 1'b1, 4'hF, BASE + 32'h18, 32'h1234_5678);
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h18, 32'd0);
        checks++;
        if (o_st !== 5'b10000 || o_rdata !== ERR) begin
            errors++; $display("FAIL err_read_18: got rdata=%h, expected deadbeef", o_rdata);
        end
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h1C, 32'd0);
        checks++;
        if (o_rdata !== ERR) begin
            errors++; $display("FAIL err_read_1c: got rdata=%h, expected deadbeef", o_rdata);
        end
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h20, 32'd0);
        checks++;
        if (o_gnt !== 1'b0 || o_st !== 5'b00000) begin
            errors++; $display("FAIL out_of_window: got gnt=%b st=%b, expected gnt=0 st=00000", o_gnt, o_st);
        end
    endtask

    // Randomized traffic against a register-level model of the peripheral.
    task automatic test_random(input int n);
        logic [31:0] m_scratch = 32'd0, m_exit = 32'd0, m_shadow = 32'd0;
        logic [7:0]  m_pchar = 8'd0;
        logic        m_term = 1'b0;
        do_reset();
        for (int t = 0; t < n; t++) begin
            logic        outw, we, e_gnt;
            logic [2:0]  off;
            logic [3:0]  be;
            logic [31:0] wd, addr, e_rd;
            logic [4:0]  e_st;
            if ($urandom_range(0, 4) == 0) begin
                cycle(1'b0, 1'b0, 4'h0, BASE, 32'd0);
                checks++;
                if (o_st !== 5'b00000) begin
                    errors++; $display("FAIL rand_idle[%0d]: got st=%b, expected 00000", t, o_st);
                end
                continue;
            end
            outw = ($urandom_range(0, 7) == 0);
            off  = 3'($urandom_range(0, 7));
            we   = 1'($urandom_range(0, 1));
            be   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            wd   = $urandom;
            if (off == 3'd1 && $urandom_range(0, 2) == 0) wd = MAGIC;
            addr = BASE + {27'd0, off, 2'b00};
            if (outw) addr = addr ^ (32'd1 << $urandom_range(5, 31));
            cycle(1'b1, we, be, addr, wd);
            e_gnt = !outw;
            e_st  = {e_gnt, 4'b0000};
            e_rd  = 32'd0;
            if (!outw) begin
                if (off == 3'd0 && we && be[0]) begin
                    m_pchar = wd[7:0]; e_st[0] = 1'b1;
                end
                if (off == 3'd1 && we && be == 4'hF && !m_term) begin
                    m_term = 1'b1;
                    if (wd == MAGIC) e_st[3] = 1'b1; else e_st[2] = 1'b1;
                end
                if (off == 3'd2 && we && be == 4'hF && !m_term) begin
                    m_term = 1'b1; m_exit = wd; e_st[1] = 1'b1;
                end
                if (off == 3'd2 && !we) e_rd = m_exit;
                if (off == 3'd3 && !we) begin
                    e_rd = c_at_drive[31:0]; m_shadow = c_at_drive[63:32];
                end
                if (off == 3'd4 && !we) e_rd = m_shadow;
                if (off == 3'd5 && we) begin
                    for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
                end
                if (off == 3'd5 && !we) e_rd = m_scratch;
                if (off >= 3'd6 && !we) e_rd = ERR;
            end
            checks++;
            if (o_gnt !== e_gnt || o_st !== e_st || o_rdata !== e_rd || o_exit !== m_exit || o_pchar !== m_pchar) begin
                errors++;
                $display("FAIL rand_txn[%0d] off=%0d we=%b be=%h: got gnt=%b st=%b rd=%h exit=%h ch=%h, expected gnt=%b st=%b rd=%h exit=%h ch=%h",
                         t, off, we, be, o_gnt, o_st, o_rdata, o_exit, o_pchar, e_gnt, e_st, e_rd, m_exit, m_pchar);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.be_i = 4'hF; bus.addr_i = BASE + 32'h08; bus.wdata_i = 32'h77;
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        bus.req_i = 1'b0;
        #1;
        checks++;
        if (exit_valid_o !== 1'b0 || bus.rvalid_o !== 1'b0 || exit_value_o !== 32'd0) begin
            errors++; $display("FAIL reset_mid_async: got ev=%b rv=%b value=%h, expected 0 0 0",
                               exit_valid_o, bus.rvalid_o, exit_value_o);
        end
        @(negedge clk_i);
        m_off  = 64'd0;
        rst_ni = 1'b1;
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'd0);
        cycle(1'b1, 1'b0, 4'hF, BASE + 32'h0C, 32'd0);
        checks++;
        if (o_rdata !== 32'd1) begin
            errors++; $display("FAIL reset_mid_counter: got lo=%h, expected 00000001", o_rdata);
        end
        cycle(1'b1, 1'b1, 4'hF, BASE + 32'h08, 32'h33);
        checks++;
        if (o_st !== 5'b10010 || o_exit !== 32'h33) begin
            errors++; $display("FAIL reset_mid_term_cleared: got st=%b value=%h, expected 10010 value=33", o_st, o_exit);
        end
    endtask

    initial begin
        test_reset();
        test_print();
        test_pass_fail();
        test_exit();
        test_counter(64'h0000_0000_FFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        test_counter(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        test_scratch_map();
        test_random(150);
        test_random(150);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
